// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the hazard detection unit:
//               FSM state encoding, stall cause codes, MDU timeout default
//               and the load-use match helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MDU_WAIT   = 2'd2
    } hdu_state_t;

    localparam logic [1:0] c_CAUSE_NONE     = 2'b00;
    localparam logic [1:0] c_CAUSE_LOAD_USE = 2'b01;
    localparam logic [1:0] c_CAUSE_MDU      = 2'b10;

    localparam int MDU_TIMEOUT_DEFAULT = 40;

    // True when the ID instruction reads a register an in-flight load will write.
    // x0 never creates a hazard because it is hard-wired to zero.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic       reg_write,
        input logic [4:0] rd,
        input logic       uses_rs1,
        input logic [4:0] rs1,
        input logic       uses_rs2,
        input logic [4:0] rs2
    );
        return mem_read && reg_write && (rd != 5'd0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter32.sv
// ============================================================================
// Module      : sat_counter32
// Description : 32-bit up counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter32 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    output logic [31:0] count
);

    localparam logic [31:0] c_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_count;

    // Count enabled cycles, holding once the maximum is reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 32'd0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_detection_unit.sv
// ============================================================================
// Module      : hazard_detection_unit
// Description : Detects load-use hazards and multi-cycle divider waits and
//               requests pipeline stalls; counts stalled cycles and flags a
//               divider that never answers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic        ex_mdu_start,
    input  logic        mdu_done,
    input  logic        flush_ex,
    output logic        stall_pipeline,
    output logic [1:0]  stall_cause,
    output logic [31:0] stall_count,
    output logic        mdu_timeout_err
);

    // Wide enough to hold MDU_TIMEOUT-1 for any legal timeout value.
    localparam int          CW          = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [CW-1:0] c_WAIT_LAST = CW'(MDU_TIMEOUT - 1);

    hdu_state_t    r_state;
    logic [CW-1:0] r_wait_cnt;
    logic          r_timeout_err;

    hdu_state_t    w_next_state;
    logic          w_load_use;
    logic          w_stall;
    logic [1:0]    w_cause;
    logic          w_timeout;

    assign w_load_use = load_use_hit(ex_mem_read, ex_reg_write, ex_rd,
                                     id_uses_rs1, id_rs1, id_uses_rs2, id_rs2);

    // Stall decision and next state; a flush cancels everything that cycle.
    always_comb begin
        w_stall      = 1'b0;
        w_cause      = c_CAUSE_NONE;
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush_ex) begin
                    w_next_state = ST_IDLE;
                end else if (ex_mdu_start) begin
                    w_stall      = 1'b1;
                    w_cause      = c_CAUSE_MDU;
                    w_next_state = ST_MDU_WAIT;
                end else if (w_load_use) begin
                    w_stall      = 1'b1;
                    w_cause      = c_CAUSE_LOAD_USE;
                    w_next_state = ST_LOAD_STALL;
                end
            end
            ST_LOAD_STALL: begin
                // The bubble is already inserted; detection is suppressed here.
                w_next_state = ST_IDLE;
            end
            ST_MDU_WAIT: begin
                if (flush_ex || mdu_done) begin
                    w_next_state = ST_IDLE;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                    w_cause = c_CAUSE_MDU;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, regardless of inputs.
    assign stall_pipeline  = w_stall & reset_n;
    assign stall_cause     = reset_n ? w_cause : c_CAUSE_NONE;
    assign mdu_timeout_err = r_timeout_err;

    // State, divider wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_MDU_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    sat_counter32 u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_pipeline),
        .count   (stall_count)
    );

endmodule

`default_nettype wire
